bsg_token_return_gen: RTL and testbench

//  Downstream-side credit return stage feeding the upstream token-in path. Counts words
//  the downstream core dequeues from the link receive FIFO and, for every 2^LG_DECIMATION

---
 rtl/bsg_token_return_gen.sv | 122 ++++++++++++
 tb/tb_bsg_token_return_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_token_return_gen.sv
// Credit return: one io_token_o toggle per 2^LG_DECIMATION dequeued words, rate-limited by TOKEN_GAP.
// Optional 16-bit issued-token counter on tokens_sent_o when BSG_TOKEN_RETURN_STATS_EN is defined.
module bsg_token_return_gen #(
  parameter int LG_DECIMATION = 3,
  parameter int PENDING_W     = 4,
  parameter int TOKEN_GAP     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 deq_i,
  output logic                 io_token_o,
  output logic [PENDING_W-1:0] pending_o,
  output logic                 overflow_o,
  output logic [15:0]          tokens_sent_o
);

  localparam int GW = (TOKEN_GAP > 1) ? $clog2(TOKEN_GAP) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

  state_e               state;
  logic [GW-1:0]        gap_cnt;
  logic                 earn;
  logic                 issue;
  logic [PENDING_W-1:0] pending_nxt;
  logic                 ovf_set;

  if (LG_DECIMATION == 0) begin : g_no_decim
    assign earn = deq_i;
  end else begin : g_decim
    logic [LG_DECIMATION-1:0] word_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        word_cnt <= '0;
      end else if (deq_i) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end

    assign earn = deq_i & (&word_cnt);
  end

  assign issue = (state == ISSUE);

  always_comb begin
    pending_nxt = pending_o;
    ovf_set     = 1'b0;
    if (earn && !issue) begin
      if (&pending_o) begin
        ovf_set = 1'b1;
      end else begin
        pending_nxt = pending_o + 1'b1;
      end
    end else if (issue && !earn) begin
      pending_nxt = pending_o - 1'b1;
    end
  end

  // Transitions look at the post-update pending count so the toggle lands in the
  // first cycle pending_o is non-zero, keeping earn-to-toggle latency at two edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      io_token_o <= 1'b0;
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else begin
      pending_o <= pending_nxt;
      if (ovf_set) begin
        overflow_o <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pending_nxt != '0) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          io_token_o <= ~io_token_o;
          if (TOKEN_GAP > 1) begin
            gap_cnt <= GW'(TOKEN_GAP - 1);
            state   <= GAP;
          end else begin
            gap_cnt <= '0;
            state   <= (pending_nxt != '0) ? ISSUE : IDLE;
          end
        end
        GAP: begin
          if (gap_cnt <= GW'(1)) begin
            gap_cnt <= '0;
            state   <= (pending_nxt != '0) ? ISSUE : IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          gap_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BSG_TOKEN_RETURN_STATS_EN
  logic [15:0] sent_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt <= '0;
    end else if (issue) begin
      sent_cnt <= sent_cnt + 16'd1;
    end
  end

  assign tokens_sent_o = sent_cnt;
`else
  assign tokens_sent_o = 16'h0000;
`endif

endmodule

// File: tb/tb_bsg_token_return_gen.sv
// Directed bench: instance a uses defaults, b is PENDING_W=2/TOKEN_GAP=16, c is LG_DECIMATION=0/TOKEN_GAP=1.
module tb_bsg_token_return_gen;

`ifdef BSG_TOKEN_RETURN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        deq_a, deq_b, deq_c;
  logic        tok_a, tok_b, tok_c;
  logic [3:0]  pend_a;
  logic [1:0]  pend_b;
  logic [3:0]  pend_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [15:0] sent_a, sent_b, sent_c;

  int checks;
  int errors;

  bsg_token_return_gen #(.LG_DECIMATION(3), .PENDING_W(4), .TOKEN_GAP(2)) dut_a (
    .clk(clk), .rst(rst), .deq_i(deq_a), .io_token_o(tok_a),
    .pending_o(pend_a), .overflow_o(ovf_a), .tokens_sent_o(sent_a));

  bsg_token_return_gen #(.LG_DECIMATION(3), .PENDING_W(2), .TOKEN_GAP(16)) dut_b (
    .clk(clk), .rst(rst), .deq_i(deq_b), .io_token_o(tok_b),
    .pending_o(pend_b), .overflow_o(ovf_b), .tokens_sent_o(sent_b));

  bsg_token_return_gen #(.LG_DECIMATION(0), .PENDING_W(4), .TOKEN_GAP(1)) dut_c (
    .clk(clk), .rst(rst), .deq_i(deq_c), .io_token_o(tok_c),
    .pending_o(pend_c), .overflow_o(ovf_c), .tokens_sent_o(sent_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    deq_a = 1'b0;
    deq_b = 1'b0;
    deq_c = 1'b0;
    rst   = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tok_a, pend_a, ovf_a, sent_a} !== 22'd0) begin
      errors++;
      $display("FAIL reset_a got tok=%0d pend=%0d ovf=%0d sent=%0d exp all 0", tok_a, pend_a, ovf_a, sent_a);
    end
    checks++;
    if ({tok_b, pend_b, ovf_b, sent_b, tok_c, pend_c, ovf_c, sent_c} !== 42'd0) begin
      errors++;
      $display("FAIL reset_bc got tok_b=%0d pend_b=%0d tok_c=%0d pend_c=%0d exp all 0", tok_b, pend_b, tok_c, pend_c);
    end
  endtask

  task automatic test_reset_mid_gap();
    logic moved;
    do_reset();
    deq_b = 1'b1;
    repeat (48) step();
    checks++;
    if (pend_b !== 2'd3 || tok_b !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_b got pend=%0d tok=%0d exp pend=3 tok=1", pend_b, tok_b);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tok_b, pend_b, ovf_b, sent_b} !== 20'd0) begin
      errors++;
      $display("FAIL rst_mid_gap got tok=%0d pend=%0d ovf=%0d sent=%0d exp all 0", tok_b, pend_b, ovf_b, sent_b);
    end
    deq_b = 1'b0;
    step();
    rst = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tok_a || tok_b || tok_c || pend_a != 0 || pend_b != 0 || pend_c != 0) moved = 1'b1;
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_quiet got activity=%0d exp 0", moved);
    end
  endtask

  task automatic test_single_token();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      deq_a = 1'b1;
      step();
      deq_a = 1'b0;
      step();
    end
    checks++;
    if (pend_a !== 4'd0 || tok_a !== 1'b0) begin
      errors++;
      $display("FAIL single_pre got pend=%0d tok=%0d exp 0 0", pend_a, tok_a);
    end
    deq_a = 1'b1;
    step();
    deq_a = 1'b0;
    checks++;
    if (pend_a !== 4'd1 || tok_a !== 1'b0) begin
      errors++;
      $display("FAIL single_earn got pend=%0d tok=%0d exp pend=1 tok=0", pend_a, tok_a);
    end
    step();
    checks++;
    if (pend_a !== 4'd0 || tok_a !== 1'b1) begin
      errors++;
      $display("FAIL single_toggle got pend=%0d tok=%0d exp pend=0 tok=1", pend_a, tok_a);
    end
    repeat (3) step();
    checks++;
    if (pend_a !== 4'd0 || tok_a !== 1'b1) begin
      errors++;
      $display("FAIL single_settle got pend=%0d tok=%0d exp pend=0 tok=1", pend_a, tok_a);
    end
  endtask

  task automatic test_burst();
    int   tog[$];
    logic prev;
    do_reset();
    prev = tok_a;
    for (int e = 1; e <= 40; e++) begin
      deq_a = (e <= 32);
      step();
      if (tok_a !== prev) tog.push_back(e);
      prev = tok_a;
    end
    deq_a = 1'b0;
    checks++;
    if (tog.size() != 4) begin
      errors++;
      $display("FAIL burst_count got %0d exp 4", tog.size());
    end
    for (int i = 0; i < tog.size() && i < 4; i++) begin
      checks++;
      if (tog[i] != 9 + 8 * i) begin
        errors++;
        $display("FAIL burst_edge%0d got %0d exp %0d", i, tog[i], 9 + 8 * i);
      end
    end
    checks++;
    if (tok_a !== 1'b0 || pend_a !== 4'd0 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL burst_final got tok=%0d pend=%0d ovf=%0d exp 0 0 0", tok_a, pend_a, ovf_a);
    end
    checks++;
    if (sent_a !== (STATS ? 16'd4 : 16'd0)) begin
      errors++;
      $display("FAIL burst_sent got %0d exp %0d", sent_a, STATS ? 4 : 0);
    end
  endtask

  task automatic test_simultaneous();
    int found;
    do_reset();
    deq_b = 1'b1;
    repeat (8) step();
    deq_b = 1'b0;
    step();
    deq_b = 1'b1;
    repeat (15) step();
    checks++;
    if (pend_b !== 2'd1 || tok_b !== 1'b1) begin
      errors++;
      $display("FAIL simul_pre got pend=%0d tok=%0d exp pend=1 tok=1", pend_b, tok_b);
    end
    step();
    deq_b = 1'b0;
    checks++;
    if (pend_b !== 2'd1 || tok_b !== 1'b0) begin
      errors++;
      $display("FAIL simul_hold got pend=%0d tok=%0d exp pend=1 tok=0", pend_b, tok_b);
    end
    found = 0;
    for (int e = 26; e <= 60 && found == 0; e++) begin
      step();
      if (tok_b !== 1'b0) found = e;
    end
    checks++;
    if (found != 41) begin
      errors++;
      $display("FAIL simul_next_edge got %0d exp 41", found);
    end
    checks++;
    if (pend_b !== 2'd0) begin
      errors++;
      $display("FAIL simul_drain got pend=%0d exp 0", pend_b);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    deq_b = 1'b1;
    repeat (55) step();
    checks++;
    if (ovf_b !== 1'b0 || pend_b !== 2'd3) begin
      errors++;
      $display("FAIL ovf_before got ovf=%0d pend=%0d exp ovf=0 pend=3", ovf_b, pend_b);
    end
    step();
    checks++;
    if (ovf_b !== 1'b1 || pend_b !== 2'd3) begin
      errors++;
      $display("FAIL ovf_set got ovf=%0d pend=%0d exp ovf=1 pend=3", ovf_b, pend_b);
    end
    repeat (8) step();
    deq_b = 1'b0;
    checks++;
    if (ovf_b !== 1'b1 || pend_b !== 2'd3 || tok_b !== 1'b0) begin
      errors++;
      $display("FAIL ovf_64 got ovf=%0d pend=%0d tok=%0d exp 1 3 0", ovf_b, pend_b, tok_b);
    end
    repeat (60) step();
    checks++;
    if (ovf_b !== 1'b1 || pend_b !== 2'd0 || tok_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drained got ovf=%0d pend=%0d tok=%0d exp 1 0 1", ovf_b, pend_b, tok_b);
    end
  endtask

  task automatic test_stats();
    do_reset();
    deq_c = 1'b1;
    repeat (5) step();
    deq_c = 1'b0;
    repeat (3) step();
    checks++;
    if (sent_c !== (STATS ? 16'd5 : 16'd0) || tok_c !== 1'b1 || pend_c !== 4'd0) begin
      errors++;
      $display("FAIL stats_short got sent=%0d tok=%0d pend=%0d exp sent=%0d tok=1 pend=0",
               sent_c, tok_c, pend_c, STATS ? 5 : 0);
    end
    do_reset();
    deq_c = 1'b1;
    for (int i = 1; i <= 65537; i++) begin
      step();
      if (i == 65536) begin
        checks++;
        if (sent_c !== (STATS ? 16'hFFFF : 16'd0) || pend_c !== 4'd1) begin
          errors++;
          $display("FAIL stats_ffff got sent=%0h pend=%0d exp sent=%0h pend=1",
                   sent_c, pend_c, STATS ? 16'hFFFF : 16'h0);
        end
      end
    end
    deq_c = 1'b0;
    repeat (3) step();
    checks++;
    if (sent_c !== (STATS ? 16'd1 : 16'd0) || tok_c !== 1'b1) begin
      errors++;
      $display("FAIL stats_wrap got sent=%0d tok=%0d exp sent=%0d tok=1", sent_c, tok_c, STATS ? 1 : 0);
    end
    checks++;
    if (pend_c !== 4'd0 || ovf_c !== 1'b0) begin
      errors++;
      $display("FAIL stats_final got pend=%0d ovf=%0d exp 0 0", pend_c, ovf_c);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    deq_a  = 1'b0;
    deq_b  = 1'b0;
    deq_c  = 1'b0;
    test_reset();
    test_reset_mid_gap();
    test_single_token();
    test_burst();
    test_simultaneous();
    test_overflow();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
